pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Fetch-side controller for the single-cycle MIPS core. It owns the PC register and sequences each instruction through a fetch/execute handshake with instruction memory. Next-PC selection is built in, with priority jump > branch > PC+4, plus stall, halt and fetch-timeout handling. It sits between the control unit and the instruction memory port, and replaces the free-running PC update path.

## Interface
- ADDR_WIDTH, 32, PC/address width; legal values ≥ 29.
- RESET_ADDR, 0, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 16, maximum FETCH cycles waiting for IMEM_READY before fault; legal values ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- STALL  input  1  hold the current instruction in EXEC.
- BRANCH  input  1  branch taken (branch & zero, already resolved).
- Branch_offset  input  ADDR_WIDTH  sign-extended word offset (instr[15:0] extended).
- JUMP  input  1  jump instruction.
- Jump_target  input  26  instr[25:0].
- HALT  input  1  halt request from the control unit.
- IMEM_READY  input  1  instruction memory has valid data for PC.
- IMEM_REQ  output  1  fetch request; PC is the fetch address.
- PC  output  ADDR_WIDTH  current program counter.
- Instr_valid  output  1  instruction at PC is valid for execution.
- Halted  output  1  core halted.
- Fetch_timeout  output  1  sticky fetch fault.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALTED, FAULT.
- IDLE: entered only from reset. Goes to FETCH on the next edge.
- FETCH: IMEM_REQ=1.
  - IMEM_READY=1 at an edge → EXEC.
  - Otherwise the wait counter increments.
  - Counter == TIMEOUT-1 with IMEM_READY=0 → FAULT.
  - If IMEM_READY=1 on the limit cycle, READY wins and the state goes to EXEC.
- EXEC: Instr_valid=1, IMEM_REQ=0. JUMP, BRANCH and HALT are sampled only here, and only when STALL=0:
  - STALL=1: stay in EXEC; PC and the counter hold.
  - HALT=1: PC holds; → HALTED. HALT has priority over JUMP and BRANCH.
  - Otherwise: PC ← next_pc; → FETCH; the wait counter clears.
- HALTED: Halted=1. PC frozen; leaves only on rst.
- FAULT: Fetch_timeout=1. PC frozen at the failing address; leaves only on rst.
- Next-PC arithmetic (all sums modulo 2^ADDR_WIDTH, carries discarded):
  - pc4 = PC + 4.
  - JUMP=1: {pc4[ADDR_WIDTH-1:28], Jump_target, 2'b00}.
  - Else if BRANCH=1: pc4 + (Branch_offset << 2).
  - Else: pc4.
- JUMP and BRANCH both asserted: JUMP wins.
- Control inputs in any state other than EXEC are ignored.

## Timing
- Reset values (in the cycle after rst is sampled high):
  - PC=RESET_ADDR; state IDLE; counter 0.
  - IMEM_REQ=0, Instr_valid=0, Halted=0, Fetch_timeout=0.
- rst dominates every state, including mid-FETCH, EXEC with STALL, HALTED and FAULT.
- Outputs are registered-state decodes with no combinational path from inputs to outputs.
- Best case: 2 cycles per instruction (FETCH with READY already high, then EXEC).
- First IMEM_REQ appears 1 cycle after rst deasserts (IDLE → FETCH).
- Each FETCH cycle with READY low adds 1 cycle of latency.
- The updated PC is visible on the edge that leaves EXEC, concurrent with IMEM_REQ rising.
- FAULT is entered on the edge ending the TIMEOUT-th consecutive FETCH cycle with READY low.

## Test plan
- Sequential run: RESET_ADDR=0, IMEM_READY tied 1, no controls → PC sequence 0x0, 0x4, 0x8. Instr_valid is high every 2nd cycle; IMEM_REQ first rises 1 cycle after rst release.
- Jump priority: PC=0x10000010, JUMP=1, BRANCH=1, Jump_target=0x0000040 → PC=0x10000100.
- Branch wrap and backward:
  - PC=0x0, BRANCH=1, Branch_offset=0xFFFFFFFF → PC=0x0.
  - PC=0xFFFFFFFC, no control → PC=0x00000000.
- Stall: 3 EXEC cycles with STALL=1 → PC, Instr_valid=1 and state hold. BRANCH pulsed during the stall and dropped before STALL releases → PC+4 taken.
- Timeout: TIMEOUT=4, IMEM_READY=0 → Fetch_timeout=1 after 4 FETCH cycles; PC unchanged. A separate run with READY=1 on the 4th cycle → EXEC, no fault.
- Halt and reset mid-operation:
  - HALT in EXEC → Halted=1; PC frozen for 10 cycles with IMEM_READY toggling.
  - rst asserted mid-FETCH → next cycle all outputs at reset values and PC=RESET_ADDR.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle between the control unit / instruction memory and the
// PC fetch sequencer. "master" is the sequencer's view, "slave" the environment's.
interface pc_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  STALL;
  logic                  BRANCH;
  logic [ADDR_WIDTH-1:0] Branch_offset;
  logic                  JUMP;
  logic [25:0]           Jump_target;
  logic                  HALT;
  logic                  IMEM_READY;
  logic                  IMEM_REQ;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  Instr_valid;
  logic                  Halted;
  logic                  Fetch_timeout;

  modport master (
    input  STALL, BRANCH, Branch_offset, JUMP, Jump_target, HALT, IMEM_READY,
    output IMEM_REQ, PC, Instr_valid, Halted, Fetch_timeout
  );

  modport slave (
    output STALL, BRANCH, Branch_offset, JUMP, Jump_target, HALT, IMEM_READY,
    input  IMEM_REQ, PC, Instr_valid, Halted, Fetch_timeout
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner for the single-cycle MIPS core: sequences IDLE -> FETCH -> EXEC,
// selects next PC (jump > branch > PC+4) and handles stall, halt and fetch timeout.
module pc_fetch_sequencer #(
  parameter int                         ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      RESET_ADDR = '0,
  parameter int                         TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_fetch_sequencer_if.master bus,
  output logic [2:0]           dbg_state
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] pc4, next_pc;

  // Fetch handshake: IMEM_REQ is held high for the whole FETCH state with PC as
  // the address; a rising edge with IMEM_READY=1 completes the fetch. No
  // back-pressure on READY exists, and Instr_valid lasts for all of EXEC.

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_ADDR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    pc4 = pc + ADDR_WIDTH'(4);
    if (bus.JUMP)
      next_pc = {pc4[ADDR_WIDTH-1:28], bus.Jump_target, 2'b00};
    else if (bus.BRANCH)
      next_pc = pc4 + (bus.Branch_offset << 2);
    else
      next_pc = pc4;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        // READY on the limit cycle still completes the fetch.
        if (bus.IMEM_READY)
          state_n = EXEC;
        else if (cnt == CW'(TIMEOUT - 1))
          state_n = FAULT;
        else
          cnt_n = cnt + CW'(1);
      end
      EXEC: begin
        if (!bus.STALL) begin
          if (bus.HALT) begin
            state_n = HALTED;
          end else begin
            state_n = FETCH;
            pc_n    = next_pc;
            cnt_n   = '0;
          end
        end
      end
      HALTED:  state_n = HALTED;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  assign bus.PC            = pc;
  assign bus.IMEM_REQ      = (state == FETCH);
  assign bus.Instr_valid   = (state == EXEC);
  assign bus.Halted        = (state == HALTED);
  assign bus.Fetch_timeout = (state == FAULT);
  assign dbg_state         = state;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: main process drives vectors and pushes
// expected {event, PC} entries; a monitor pops them on each EXEC/HALTED/FAULT entry.
module tb_pc_fetch_sequencer;
  localparam int AW = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                         S_HALTED = 3'd3, S_FAULT = 3'd4;
  localparam logic [3:0] EV_EXEC = 4'd1, EV_HALT = 4'd2, EV_FAULT = 4'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  pc_fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  pc_fetch_sequencer #(
    .ADDR_WIDTH(AW),
    .RESET_ADDR(32'h0),
    .TIMEOUT   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising Instr_valid / Halted / Fetch_timeout is one output event.
  logic prev_v = 1'b0, prev_h = 1'b0, prev_f = 1'b0;
  always @(negedge clk) begin
    logic [3:0]  kind;
    logic [35:0] e;
    kind = 4'd0;
    if (bus.Instr_valid && !prev_v)   kind = EV_EXEC;
    if (bus.Halted && !prev_h)        kind = EV_HALT;
    if (bus.Fetch_timeout && !prev_f) kind = EV_FAULT;
    if (kind != 4'd0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d pc 0x%0h, expected none", kind, bus.PC);
      end else begin
        e = exp_q.pop_front();
        check("event", {28'd0, kind, bus.PC}, {28'd0, e});
      end
    end
    prev_v = bus.Instr_valid;
    prev_h = bus.Halted;
    prev_f = bus.Fetch_timeout;
  end

  task automatic clear_ctl();
    bus.STALL = 1'b0;
    bus.BRANCH = 1'b0;
    bus.JUMP = 1'b0;
    bus.HALT = 1'b0;
    bus.Branch_offset = '0;
    bus.Jump_target = '0;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    clear_ctl();
    bus.IMEM_READY = ready;
    @(posedge clk); #1;
    check("rst_pc", bus.PC, 32'h0);
    check("rst_outs", {bus.IMEM_REQ, bus.Instr_valid, bus.Halted, bus.Fetch_timeout}, 4'b0000);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
  endtask

  task automatic step(input logic j, input logic b, input logic h,
                      input logic [31:0] off, input logic [25:0] tgt);
    bus.JUMP = j;
    bus.BRANCH = b;
    bus.HALT = h;
    bus.Branch_offset = off;
    bus.Jump_target = tgt;
    @(posedge clk); #1;
    clear_ctl();
  endtask

  task automatic wait_exec(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.Instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: no EXEC within 20 cycles, state %0d", name, dbg_state);
    end
  endtask

  initial begin
    clear_ctl();
    bus.IMEM_READY = 1'b1;
    #2;

    // Sequential run
    do_reset(1'b1);
    exp_q.push_back({EV_EXEC, 32'h0});
    @(posedge clk); #1;
    check("first_req", {bus.IMEM_REQ, bus.Instr_valid, dbg_state}, {1'b1, 1'b0, S_FETCH});
    wait_exec("seq0");
    check("seq0_valid", {bus.Instr_valid, bus.IMEM_REQ}, 2'b10);
    exp_q.push_back({EV_EXEC, 32'h4});
    step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    check("seq_pc_on_req", {bus.IMEM_REQ, bus.Instr_valid, bus.PC}, {1'b1, 1'b0, 32'h4});
    wait_exec("seq4");
    exp_q.push_back({EV_EXEC, 32'h8});
    step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    wait_exec("seq8");

    // Forward branch from 0x8: 0xC + 4*0x04000001 = 0x10000010
    exp_q.push_back({EV_EXEC, 32'h1000_0010});
    step(1'b0, 1'b1, 1'b0, 32'h0400_0001, 26'h0);
    wait_exec("br_fwd");

    // Jump beats branch: {0x1, 0x40, 00} with pc4 = 0x10000014
    exp_q.push_back({EV_EXEC, 32'h1000_0100});
    step(1'b1, 1'b1, 1'b0, 32'h0000_0005, 26'h000_0040);
    wait_exec("jump_prio");

    // Branch to 0xFFFFFFFC: 0x10000104 + 0xEFFFFEF8
    exp_q.push_back({EV_EXEC, 32'hFFFF_FFFC});
    step(1'b0, 1'b1, 1'b0, 32'h3BFF_FFBE, 26'h0);
    wait_exec("br_top");

    // PC+4 wraps
    exp_q.push_back({EV_EXEC, 32'h0});
    step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    wait_exec("wrap");

    // Backward branch of -1 word from 0 lands on 0
    exp_q.push_back({EV_EXEC, 32'h0});
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'h0);
    wait_exec("br_back");

    // Stall: BRANCH pulsed while stalled, dropped before release
    for (int i = 0; i < 3; i++) begin
      bus.STALL = 1'b1;
      bus.BRANCH = (i < 2);
      bus.Branch_offset = 32'h0000_0100;
      @(posedge clk); #1;
      check("stall_hold", {bus.PC, bus.Instr_valid, dbg_state}, {32'h0, 1'b1, S_EXEC});
    end
    clear_ctl();
    exp_q.push_back({EV_EXEC, 32'h4});
    step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    check("stall_release", {bus.PC, dbg_state}, {32'h4, S_FETCH});
    wait_exec("post_stall");

    // READY arrives on the 4th (limit) FETCH cycle: no fault
    bus.IMEM_READY = 1'b0;
    exp_q.push_back({EV_EXEC, 32'h8});
    step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("limit_wait", {dbg_state, bus.Fetch_timeout}, {S_FETCH, 1'b0});
    bus.IMEM_READY = 1'b1;
    @(posedge clk); #1;
    check("limit_ready", {dbg_state, bus.Fetch_timeout, bus.PC}, {S_EXEC, 1'b0, 32'h8});

    // Halt (over JUMP), then frozen with READY toggling and controls wiggling
    exp_q.push_back({EV_HALT, 32'h8});
    step(1'b1, 1'b0, 1'b1, 32'h0, 26'h3FF_FFFF);
    check("halted", {bus.Halted, bus.PC, bus.IMEM_REQ, bus.Instr_valid}, {1'b1, 32'h8, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      bus.IMEM_READY = i[0];
      bus.JUMP = ~i[0];
      bus.Jump_target = 26'h123_4567;
      @(posedge clk); #1;
      check("halt_frozen", {bus.Halted, bus.PC, dbg_state}, {1'b1, 32'h8, S_HALTED});
    end

    // Timeout: 4 FETCH cycles with READY low -> FAULT, PC unchanged
    do_reset(1'b0);
    exp_q.push_back({EV_FAULT, 32'h0});
    repeat (4) begin @(posedge clk); #1; end
    check("pre_fault", {dbg_state, bus.Fetch_timeout}, {S_FETCH, 1'b0});
    @(posedge clk); #1;
    check("fault", {bus.Fetch_timeout, bus.PC, bus.IMEM_REQ}, {1'b1, 32'h0, 1'b0});
    bus.IMEM_READY = 1'b1;
    bus.JUMP = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("fault_sticky", {bus.Fetch_timeout, bus.PC, dbg_state}, {1'b1, 32'h0, S_FAULT});
    clear_ctl();

    // Reset mid-FETCH, then one clean fetch
    do_reset(1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_fetch", {dbg_state, bus.IMEM_REQ}, {S_FETCH, 1'b1});
    do_reset(1'b1);
    exp_q.push_back({EV_EXEC, 32'h0});
    @(posedge clk); #1;
    wait_exec("after_rst");

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1, "watchdog");
  end
endmodule
